// File: rtl/dmem_port.sv
// Data-memory port: turns a held load/store request into one valid/ready bus
// transaction with alignment checks, lane steering and a bus-cycle timeout.
module dmem_port #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    output logic [XLEN-1:0]   rdata,
    output logic              ready,
    output logic              error,
    output logic              busy,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_ready,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err,
    output logic [1:0]        dbg_state
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2, FAULT = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               we_q, we_d;
    logic [OFF_W-1:0]   off_q, off_d;

    logic [OFF_W-1:0]   offset, align_mask;
    logic [STRB_W-1:0]  size_mask;
    logic               has_req, illegal, misaligned;

    // Request decode; only consumed while IDLE.
    always_comb begin
        offset     = req_addr[OFF_W-1:0];
        size_mask  = STRB_W'(1);
        align_mask = '0;
        case (req_size)
            3'd1:    begin size_mask = STRB_W'(3);    align_mask = OFF_W'(1); end
            3'd2:    begin size_mask = STRB_W'(15);   align_mask = OFF_W'(3); end
            3'd3:    begin size_mask = STRB_W'(8'hFF); align_mask = OFF_W'(7); end
            default: begin size_mask = STRB_W'(1);    align_mask = '0;        end
        endcase
        has_req    = req_read | req_write;
        illegal    = (req_read & req_write) | (req_size > 3'd3) |
                     ((XLEN == 32) && (req_size == 3'd3));
        misaligned = (offset & align_mask) != '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (has_req) begin
                    if (illegal || misaligned) begin
                        state_d = FAULT;
                    end else begin
                        state_d = BUS;
                        addr_d  = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        we_d    = req_write;
                        wdata_d = req_wdata << {offset, 3'b000};
                        wstrb_d = req_write ? (size_mask << offset) : '0;
                        off_d   = offset;
                    end
                end
            end
            BUS: begin
                // A bus_ready in the final allowed cycle beats the timeout.
                if (bus_ready) begin
                    cnt_d   = '0;
                    state_d = bus_err ? FAULT : DONE;
                    if (!we_q) rdata_d = bus_rdata >> {off_q, 3'b000};
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // valid/ready: bus_valid and all bus_* stay stable from entry into BUS until
    // the cycle bus_ready is seen high; the transfer completes on that edge.
    assign bus_valid = (state_q == BUS);
    assign ready     = (state_q == DONE);
    assign error     = (state_q == FAULT);
    assign busy      = (state_q != IDLE);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port (XLEN=64, TIMEOUT=8): loads, stores, faults,
// timeout and asynchronous reset during a bus cycle.
module tb_dmem_port;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            resetn;
    logic [XLEN-1:0] req_addr, req_wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic            req_read, req_write, ready, error, busy, bus_valid, bus_we;
    logic            bus_ready, bus_err;
    logic [2:0]      req_size;
    logic [7:0]      bus_wstrb;
    logic [1:0]      dbg_state;

    int errors = 0;
    int checks = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    dmem_port #(.XLEN(XLEN), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_read(req_read),
        .req_write(req_write), .req_size(req_size),
        .rdata(rdata), .ready(ready), .error(error), .busy(busy),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    always @(negedge clk) if (ready && error) overlap_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_addr  = '0;
        req_wdata = '0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_size  = 3'd0;
        bus_ready = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({rdata, ready, error, busy, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b addr=%h rdata=%h, expected all zero",
                     bus_valid, busy, bus_addr, rdata);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_load_word();
        req_addr = 64'h1004; req_size = 3'd2; req_read = 1'b1;
        step();
        checks++;
        if ({bus_valid, bus_we, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 8'h00, 64'h1000}) begin
            errors++;
            $display("FAIL ldw_bus: valid=%b we=%b strb=%h addr=%h expected 1 0 00 1000",
                     bus_valid, bus_we, bus_wstrb, bus_addr);
        end
        bus_ready = 1'b1; bus_rdata = 64'h89ABCDEF_01234567;
        step();
        checks++;
        if ({ready, error, bus_valid, rdata} !== {1'b1, 1'b0, 1'b0, 64'h89ABCDEF}) begin
            errors++;
            $display("FAIL ldw_done: ready=%b error=%b valid=%b rdata=%h expected 1 0 0 89abcdef",
                     ready, error, bus_valid, rdata);
        end
        clear_inputs();
        step();
        checks++;
        if ({ready, busy} !== 2'b00) begin errors++; $display("FAIL ldw_idle: ready=%b busy=%b expected 0 0", ready, busy); end
    endtask

    task automatic test_store_byte();
        logic [137:0] exp_bus;
        req_addr = 64'h2003; req_size = 3'd0; req_wdata = 64'hA5; req_write = 1'b1;
        exp_bus = {1'b1, 1'b1, 8'h08, 64'h2000, 64'hA500_0000};
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== exp_bus) begin
                errors++;
                $display("FAIL stb_stable[%0d]: valid=%b we=%b strb=%h addr=%h wdata=%h expected 1 1 08 2000 a5000000",
                         i, bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata);
            end
            if (i == 3) bus_ready = 1'b1;
            else step();
        end
        step();
        checks++;
        if ({ready, error, rdata} !== {1'b1, 1'b0, 64'h89ABCDEF}) begin
            errors++;
            $display("FAIL stb_done: ready=%b error=%b rdata=%h expected 1 0 89abcdef", ready, error, rdata);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_half_steer();
        req_addr = 64'h1006; req_size = 3'd1; req_read = 1'b1;
        step();
        bus_ready = 1'b1; bus_rdata = 64'h89ABCDEF_01234567;
        step();
        checks++;
        if ({ready, rdata} !== {1'b1, 64'h89AB}) begin
            errors++;
            $display("FAIL ldh_steer: ready=%b rdata=%h expected 1 89ab", ready, rdata);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_misaligned();
        req_addr = 64'h3001; req_size = 3'd1; req_read = 1'b1;
        step();
        checks++;
        if ({error, ready, bus_valid} !== 3'b100) begin
            errors++;
            $display("FAIL misal_pulse: error=%b ready=%b valid=%b expected 1 0 0", error, ready, bus_valid);
        end
        clear_inputs();
        step();
        checks++;
        if ({error, busy, bus_valid} !== 3'b000) begin
            errors++;
            $display("FAIL misal_after: error=%b busy=%b valid=%b expected 0 0 0", error, busy, bus_valid);
        end
    endtask

    task automatic test_illegal();
        req_addr = 64'h7000; req_size = 3'd2; req_read = 1'b1; req_write = 1'b1;
        step();
        checks++;
        if ({error, bus_valid} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_rw: error=%b valid=%b expected 1 0", error, bus_valid);
        end
        clear_inputs();
        step();
        req_addr = 64'h7000; req_size = 3'd4; req_read = 1'b1;
        step();
        checks++;
        if ({error, bus_valid} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_size: error=%b valid=%b expected 1 0", error, bus_valid);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        int  valid_cnt;
        logic seen_err;
        valid_cnt = 0;
        seen_err  = 1'b0;
        req_addr = 64'h4000; req_size = 3'd3; req_read = 1'b1;
        for (int i = 0; i < 20 && !seen_err; i++) begin
            step();
            if (bus_valid) valid_cnt++;
            if (error) seen_err = 1'b1;
        end
        checks++;
        if (valid_cnt != 8) begin errors++; $display("FAIL timeout_len: valid cycles=%0d expected 8", valid_cnt); end
        checks++;
        if (seen_err !== 1'b1) begin errors++; $display("FAIL timeout_err: error seen=%b expected 1", seen_err); end
        clear_inputs();
        step();
        checks++;
        if ({busy, error} !== 2'b00) begin errors++; $display("FAIL timeout_idle: busy=%b error=%b expected 0 0", busy, error); end
    endtask

    task automatic test_bus_err();
        req_addr = 64'h5000; req_size = 3'd2; req_read = 1'b1;
        step();
        bus_ready = 1'b1; bus_err = 1'b1;
        step();
        checks++;
        if ({error, ready} !== 2'b10) begin
            errors++;
            $display("FAIL buserr_pulse: error=%b ready=%b expected 1 0", error, ready);
        end
        clear_inputs();
        step();
        checks++;
        if ({error, ready} !== 2'b00) begin
            errors++;
            $display("FAIL buserr_after: error=%b ready=%b expected 0 0", error, ready);
        end
    endtask

    task automatic test_reset_mid_bus();
        req_addr = 64'h6008; req_size = 3'd2; req_read = 1'b1;
        step();
        checks++;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: valid=%b expected 1", bus_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({bus_valid, ready, error, busy, bus_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: valid=%b ready=%b error=%b busy=%b addr=%h expected all 0",
                     bus_valid, ready, error, busy, bus_addr);
        end
        step();
        resetn = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy=%b expected 0", busy); end
        step();
        checks++;
        if ({bus_valid, bus_addr} !== {1'b1, 64'h6008}) begin
            errors++;
            $display("FAIL rst_mid_restart: valid=%b addr=%h expected 1 6008", bus_valid, bus_addr);
        end
        bus_ready = 1'b1; bus_rdata = 64'h11223344_55667788;
        step();
        checks++;
        if ({ready, rdata} !== {1'b1, 64'h11223344_55667788}) begin
            errors++;
            $display("FAIL rst_mid_done: ready=%b rdata=%h expected 1 1122334455667788", ready, rdata);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL ready_error_overlap: cycles=%0d expected 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half_steer();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_bus_err();
        test_reset_mid_bus();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
